demux_1to4_buf: RTL
===================

# demux_1to4_buf

Buffered 1-to-4 demultiplexer: accepts a tagged data word on a single valid/ready input channel and delivers it to exactly one of four valid/ready output channels chosen by the 2-bit `i_select` tag. It is the distributing counterpart to the 4-to-1 selector in the RV32I pipeline, routing a single producer (e.g. resolved branch/redirect results) to one of four consumers. A 2-entry FIFO decouples producer and consumers and sustains one word per cycle with no combinational ready path from outputs to input.

## Interface
- `d_width`, 32, data word width in bits
- `i_clk`  input  1  clock, all state updates on rising edge
- `i_rst`  input  1  reset; one clock, synchronous, active-high
- `i_valid`  input  1  input word valid
- `o_ready`  output  1  buffer can accept a word this cycle
- `i_data`  input  d_width  input word
- `i_select`  input  2  destination index 0..3, sampled with `i_data`
- `o_valid0`..`o_valid3`  output  1 each  word pending for destination k
- `i_ready0`..`i_ready3`  input  1 each  destination k accepts
- `o_data0`..`o_data3`  output  d_width each  head word for destination k, zero when not addressed
- `o_cnt0`..`o_cnt3`  output  16 each  delivered-word counters (see Configuration)

## Operation
- Storage: 2 entries of {select[1:0], data}, 1-bit write pointer, 1-bit read pointer, 2-bit occupancy count (0, 1, 2).
- States by occupancy: EMPTY (0), ONE (1), FULL (2).
- `o_ready` = (count != 2); depends only on registered state.
- push = `i_valid` && `o_ready`; writes {i_select, i_data} at write pointer, pointer toggles.
- Head = entry at read pointer. For k = head select and count != 0: `o_valid`k = 1, `o_data`k = head data; all other `o_valid` = 0, other `o_data` = 0.
- pop = `o_valid`k && `i_ready`k for the addressed k; read pointer toggles. `i_ready` of non-addressed outputs is ignored.
- Transitions: EMPTY -push-> ONE; ONE -push only-> FULL; ONE -pop only-> EMPTY; ONE -push&pop-> ONE; FULL -pop-> ONE. Push in FULL is impossible (`o_ready` = 0); pop in EMPTY is impossible.
- Order: words leave strictly in acceptance order; a stalled destination blocks words behind it for other destinations (no reordering).
- `i_valid` with `o_ready` = 0: word not taken; producer must hold it.
- Destination must not drop `o_valid`k before its `i_ready`k; block guarantees held head data/select while stalled.

## Timing
- Reset: count = 0, both pointers = 0, `o_ready` = 1 is asserted the cycle after reset is released (reset itself forces `o_ready` = 0 while `i_rst` = 1), all `o_valid` = 0, all `o_data` = 0, all `o_cnt` = 0. Buffer contents need not be cleared.
- Reset mid-operation: pending words discarded, all outputs return to reset values on the next edge.
- Latency: word pushed at edge N is visible on `o_valid`k/`o_data`k during cycle after N (1 cycle) when buffer was EMPTY.
- Throughput: 1 word/cycle sustained when the addressed destination holds ready high.
- Simultaneous push and pop in ONE: count stays 1, new word becomes head next cycle.
- Pointer wrap: 1-bit pointers wrap 1 -> 0 naturally.

## Configuration
- `DEMUX_1TO4_STATS_EN` defined: `o_cnt`k increments by 1 on every pop to destination k; 16-bit, wraps 0xFFFF -> 0x0000; cleared by `i_rst`.
- Not defined: counter registers are not built; `o_cnt0`..`o_cnt3` tied to 0. Port list unchanged.

## Test plan
- Reset: hold `i_rst` 2 cycles with `i_valid` = 1 -> all `o_valid` = 0, `o_data`k = 0, `o_cnt`k = 0; `o_ready` = 1 first cycle after release.
- Route: push 0xDEADBEEF sel 2, all `i_ready` = 1 -> next cycle only `o_valid2` = 1, `o_data2` = 0xDEADBEEF, others 0; pop; `o_cnt2` = 1 with stats enabled.
- Back-pressure: `i_ready1` = 0, push 0x11 sel 1, 0x22 sel 3, 0x33 sel 0 -> `o_ready` = 0 after second push, 0x33 held by producer; raise `i_ready1` -> 0x11 out, then 0x22 on `o_data3`, then 0x33 on `o_data0`, in order.
- Head-of-line: head sel 0 stalled, second entry sel 3 with `i_ready3` = 1 -> `o_valid3` stays 0 until head pops.
- Streaming: 100 consecutive pushes cycling sel 0,1,2,3 with all readies high -> one delivery per cycle, each `o_cnt`k = 25, `o_ready` never drops.
- Mid-flight reset in FULL -> next cycle EMPTY, no `o_valid`, counters 0; stats-disabled build: `o_cnt`k always 0.

Source files
------------

// File: rtl/demux_1to4_buf_if.sv
// Bus bundle for demux_1to4_buf: one tagged valid/ready input channel
// and four valid/ready output lanes, each carrying its delivered-word counter.
interface demux_1to4_buf_if #(
    parameter int d_width = 32
);
    logic                      i_valid;
    logic                      o_ready;
    logic [d_width-1:0]        i_data;
    logic [1:0]                i_select;
    logic [3:0]                o_valid;
    logic [3:0]                i_ready;
    logic [3:0][d_width-1:0]   o_data;
    logic [3:0][15:0]          o_cnt;

    modport slave (
        input  i_valid, i_data, i_select, i_ready,
        output o_ready, o_valid, o_data, o_cnt
    );

    modport master (
        output i_valid, i_data, i_select, i_ready,
        input  o_ready, o_valid, o_data, o_cnt
    );
endinterface

// File: rtl/demux_1to4_buf.sv
// Buffered 1-to-4 demux: 2-entry FIFO of {select, data} feeding four lanes.
// Define DEMUX_1TO4_STATS_EN to build the per-lane delivered-word counters.

module demux_1to4_buf_lane #(
    parameter int d_width = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               hit,
    input  logic [d_width-1:0] head_data,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [d_width-1:0] o_data,
    output logic [15:0]        o_cnt,
    output logic               pop
);
    assign o_valid = hit;
    assign o_data  = hit ? head_data : '0;
    assign pop     = hit && i_ready;

`ifdef DEMUX_1TO4_STATS_EN
    logic [15:0] cnt_q;
    always_ff @(posedge i_clk) begin
        if (i_rst)
            cnt_q <= '0;
        else if (pop)
            cnt_q <= cnt_q + 16'd1;
    end
    assign o_cnt = cnt_q;
`else
    logic unused_clk_rst;
    assign unused_clk_rst = i_clk ^ i_rst;
    assign o_cnt          = '0;
`endif
endmodule

module demux_1to4_buf #(
    parameter int d_width = 32
) (
    input  logic           i_clk,
    input  logic           i_rst,
    demux_1to4_buf_if.slave bus
);
    localparam int NUM_LANES = 4;

    // State value doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                   state, state_nxt;
    logic [1:0][d_width+1:0]  mem;
    logic                     wr_ptr, rd_ptr;
    logic                     push, pop, nonempty;
    logic [1:0]               head_sel;
    logic [d_width-1:0]       head_data;
    logic [NUM_LANES-1:0]     lane_pop;

    assign bus.o_ready = !i_rst && (state != FULL);
    assign push        = bus.i_valid && bus.o_ready;
    assign nonempty    = (state != EMPTY);
    assign head_sel    = mem[rd_ptr][d_width+1:d_width];
    assign head_data   = mem[rd_ptr][d_width-1:0];
    assign pop         = |lane_pop;

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (push) state_nxt = ONE;
            ONE: begin
                if (push && !pop)      state_nxt = FULL;
                else if (pop && !push) state_nxt = EMPTY;
            end
            FULL:  if (pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
        end
    end

    // Payload storage is left uncleared; occupancy alone decides what is visible.
    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr] <= {bus.i_select, bus.i_data};
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        demux_1to4_buf_lane #(.d_width(d_width)) u_lane (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .hit       (nonempty && (head_sel == 2'(k))),
            .head_data (head_data),
            .i_ready   (bus.i_ready[k]),
            .o_valid   (bus.o_valid[k]),
            .o_data    (bus.o_data[k]),
            .o_cnt     (bus.o_cnt[k]),
            .pop       (lane_pop[k])
        );
    end
endmodule
